// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: default sizes, FSM and grant encodings.
// Used by mem_arbiter and mem_lat_timer.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_SIZE   = 8;
  localparam int WORD_SIZE_BIT   = 32;
  localparam int DEF_MEM_LATENCY = 4;
  localparam int DEF_STARVE_MAX  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } arb_grant_t;

  // Saturating 16-bit increment used by the optional statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    sat_inc16 = (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Fixed-latency access timer: loaded on grant, counts down while the arbiter is BUSY,
// and flags expire in the last BUSY cycle.
module mem_lat_timer
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic busy,
  output logic expire
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] lat_cnt_r;

  // Latency countdown; holds at zero once the access has expired.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_cnt_r <= '0;
    end else if (load) begin
      lat_cnt_r <= LOAD_VAL;
    end else if (busy && (lat_cnt_r != '0)) begin
      lat_cnt_r <= lat_cnt_r - CNT_ONE;
    end else begin
      lat_cnt_r <= lat_cnt_r;
    end
  end

  assign expire = busy && (lat_cnt_r == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter (refill read vs. write-buffer drain) with fixed latency.
// Optional grant/conflict statistics outputs are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_SIZE,
  parameter int DATA_W      = WORD_SIZE_BIT,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int STARVE_MAX  = DEF_STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_full,
  output logic              wb_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       rd_grant_cnt,
  output logic [15:0]       wb_grant_cnt,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

  arb_state_t          state_r;
  arb_grant_t          gnt_r;
  arb_grant_t          gnt_s;
  logic                req_any_s;
  logic                load_s;
  logic                busy_s;
  logic                expire_s;
  logic [STARVE_W-1:0] starve_r;

  // Grant decision for the current IDLE cycle: a full buffer or a starved drain beats a read.
  always_comb begin
    gnt_s     = GNT_RD;
    req_any_s = rd_req || wb_req;
    if (wb_req && wb_full) begin
      gnt_s = GNT_WR;
    end else if (wb_req && (starve_r == STARVE_LIM)) begin
      gnt_s = GNT_WR;
    end else if (rd_req) begin
      gnt_s = GNT_RD;
    end else if (wb_req) begin
      gnt_s = GNT_WR;
    end else begin
      gnt_s = GNT_RD;
    end
  end

  assign load_s = (state_r == IDLE) && req_any_s;
  assign busy_s = (state_r == BUSY);

  mem_lat_timer #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_lat_timer (
    .clock (clock),
    .reset (reset),
    .load  (load_s),
    .busy  (busy_s),
    .expire(expire_s)
  );

  // Access sequencer: latches the grant, drives the memory port and issues the completion pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      gnt_r     <= GNT_RD;
      starve_r  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
      rd_done   <= 1'b0;
      wb_ack    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rd_done <= 1'b0;
          wb_ack  <= 1'b0;
          if (req_any_s) begin
            state_r <= BUSY;
            gnt_r   <= gnt_s;
            mem_en  <= 1'b1;
            if (gnt_s == GNT_WR) begin
              mem_we    <= 1'b1;
              mem_addr  <= wb_addr;
              mem_wdata <= wb_data;
              starve_r  <= '0;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= rd_addr;
              mem_wdata <= '0;
              // Only reads that bypass a waiting drain count toward starvation.
              if (wb_req && (starve_r != STARVE_LIM)) begin
                starve_r <= starve_r + STARVE_ONE;
              end else begin
                starve_r <= starve_r;
              end
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (expire_s) begin
            state_r <= RESP;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if (gnt_r == GNT_RD) begin
              rd_data <= mem_rdata;
              rd_done <= 1'b1;
            end else begin
              wb_ack  <= 1'b1;
            end
          end else begin
            state_r <= BUSY;
          end
        end
        RESP: begin
          state_r <= IDLE;
          rd_done <= 1'b0;
          wb_ack  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          rd_done <= 1'b0;
          wb_ack  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Grant and conflict statistics, counted once per IDLE decision and saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_grant_cnt <= 16'h0000;
      wb_grant_cnt <= 16'h0000;
      conflict_cnt <= 16'h0000;
    end else if (load_s) begin
      if (gnt_s == GNT_WR) begin
        wb_grant_cnt <= sat_inc16(wb_grant_cnt);
      end else begin
        rd_grant_cnt <= sat_inc16(rd_grant_cnt);
      end
      if (rd_req && wb_req) begin
        conflict_cnt <= sat_inc16(conflict_cnt);
      end else begin
        conflict_cnt <= conflict_cnt;
      end
    end else begin
      rd_grant_cnt <= rd_grant_cnt;
      wb_grant_cnt <= wb_grant_cnt;
      conflict_cnt <= conflict_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int LAT  = 4;
  localparam int SMAX = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_done;
  logic [DW-1:0] rd_data;
  logic          wb_req = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_full = 1'b0;
  logic          wb_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]   rd_grant_cnt;
  logic [15:0]   wb_grant_cnt;
  logic [15:0]   conflict_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_full(wb_full),
    .wb_ack(wb_ack), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .rd_grant_cnt(rd_grant_cnt), .wb_grant_cnt(wb_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string nm, input string act, input string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got '%s', expected '%s'", nm, act, exp);
    end
  endtask

  // Power-on memory contents; address 8'h8C holds 783.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 8'h8C) return 32'd783;
    return 32'(a) * 32'h0100_0193 + 32'd7;
  endfunction

  // Memory model on the DUT side: data is only valid in the last enabled cycle.
  logic [DW-1:0] wr_arr [256];
  bit            wr_vld [256];
  int unsigned   mem_cnt = 0;
  logic [DW-1:0] mem_word;
  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      wr_arr[mem_addr] <= mem_wdata;
      wr_vld[mem_addr] <= 1'b1;
    end
    mem_cnt <= mem_en ? mem_cnt + 1 : 0;
  end
  always_comb begin
    mem_word  = wr_vld[mem_addr] ? wr_arr[mem_addr] : init_val(mem_addr);
    mem_rdata = (mem_cnt == LAT - 1) ? mem_word : ~mem_word;
  end

  // Reference model: tracks where in the LAT+2 cycle access window we are.
  int            phase = 0;
  bit            m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] exp_rd_data = '0;
  int            starve = 0;
  int            m_rdc = 0, m_wbc = 0, m_conf = 0;
  string         glog = "";
  logic [DW-1:0] ref_dat [256];
  bit            ref_vld [256];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      phase = 0; starve = 0; exp_rd_data = '0;
      m_rdc = 0; m_wbc = 0; m_conf = 0;
    end else if (phase == 0) begin
      if (rd_req || wb_req) begin
        if (rd_req && wb_req) m_conf++;
        m_wr = wb_req && (wb_full || starve == SMAX || !rd_req);
        if (m_wr) begin
          starve = 0; m_addr = wb_addr; m_data = wb_data;
          ref_dat[wb_addr] = wb_data; ref_vld[wb_addr] = 1'b1;
          m_wbc++; glog = {glog, "W"};
        end else begin
          if (wb_req && starve < SMAX) starve++;
          m_addr = rd_addr;
          m_rdc++; glog = {glog, "R"};
        end
        phase = 1;
      end
    end else if (phase <= LAT) begin
      phase++;
      if (phase == LAT + 1 && !m_wr)
        exp_rd_data = ref_vld[m_addr] ? ref_dat[m_addr] : init_val(m_addr);
    end else begin
      phase = 0;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clock) begin
    bit exp_en;
    exp_en = (phase >= 1) && (phase <= LAT);
    chk("mem_en", mem_en, exp_en);
    chk("rd_done", rd_done, (phase == LAT + 1) && !m_wr);
    chk("wb_ack", wb_ack, (phase == LAT + 1) && m_wr);
    chk("rd_data", rd_data, exp_rd_data);
    if (exp_en) begin
      chk("mem_we", mem_we, m_wr);
      chk("mem_addr", mem_addr, m_addr);
      if (m_wr) chk("mem_wdata", mem_wdata, m_data);
    end
`ifdef MEM_ARB_STATS_EN
    chk("rd_grant_cnt", rd_grant_cnt, m_rdc);
    chk("wb_grant_cnt", wb_grant_cnt, m_wbc);
    chk("conflict_cnt", conflict_cnt, m_conf);
`endif
  end

  task automatic single_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d);
    @(negedge clock);
    rd_addr = a; rd_req = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clock);
      chk("rd_dir_en", mem_en, c <= LAT);
      if (c <= LAT) chk("rd_dir_we", mem_we, 1'b0);
      chk("rd_dir_done", rd_done, c == LAT + 1);
      chk("rd_dir_ack", wb_ack, 1'b0);
      if (c == LAT + 1) begin
        chk("rd_dir_data", rd_data, exp_d);
        rd_req = 1'b0;
      end
    end
  endtask

  initial begin
    int    en_seen;
    int    gstart;
    int    cyc;
    string order;

    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Idle: nothing may happen without requests.
    en_seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (mem_en || rd_done || wb_ack) en_seen++;
    end
    chk("idle_activity", en_seen, 0);
    chk("idle_rd_data", rd_data, 0);

    single_read(8'h8C, 32'd783);

    // Single write of 763 to 8'hC4.
    @(negedge clock);
    wb_addr = 8'hC4; wb_data = 32'd763; wb_req = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clock);
      chk("wr_dir_en", mem_en, c <= LAT);
      if (c <= LAT) begin
        chk("wr_dir_we", mem_we, 1'b1);
        chk("wr_dir_wdata", mem_wdata, 32'd763);
        chk("wr_dir_addr", mem_addr, 8'hC4);
      end
      chk("wr_dir_ack", wb_ack, c == LAT + 1);
      chk("wr_dir_rd_done", rd_done, 1'b0);
      if (c == LAT + 1) wb_req = 1'b0;
    end
    single_read(8'hC4, 32'd763);

    // Both requesters held continuously: starvation limit forces every fourth grant.
    @(negedge clock);
    gstart = glog.len();
    rd_addr = 8'h10; wb_addr = 8'h20; wb_data = 32'hA5A5_0001; wb_full = 1'b0;
    rd_req = 1'b1; wb_req = 1'b1;
    order = ""; cyc = 0;
    while (order.len() < 8 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (rd_done) order = {order, "R"};
      if (wb_ack) order = {order, "W"};
    end
    rd_req = 1'b0; wb_req = 1'b0;
    chk_str("starve_order_dut", order, "RRRWRRRW");
    chk_str("starve_order_model", glog.substr(gstart, gstart + 7), "RRRWRRRW");
`ifdef MEM_ARB_STATS_EN
    chk("starve_conflicts", conflict_cnt, 16'd8);
`endif

    // A full write buffer wins over a pending read.
    @(negedge clock);
    rd_addr = 8'h30; wb_addr = 8'h40; wb_data = 32'h0000_BEEF;
    rd_req = 1'b1; wb_req = 1'b1; wb_full = 1'b1;
    order = ""; cyc = 0;
    while (order.len() < 2 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (wb_ack) begin order = {order, "W"}; wb_req = 1'b0; wb_full = 1'b0; end
      if (rd_done) begin order = {order, "R"}; rd_req = 1'b0; end
    end
    chk_str("full_order", order, "WR");

    // Reset during the second BUSY cycle of a read aborts it.
    @(negedge clock);
    rd_addr = 8'h8C; rd_req = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1; rd_req = 1'b0;
    #1;
    chk("abort_mem_en", mem_en, 1'b0);
    chk("abort_rd_done", rd_done, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    en_seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (rd_done || mem_en) en_seen++;
    end
    chk("abort_no_done", en_seen, 0);
    single_read(8'h8C, 32'd783);

    // Randomized traffic over a small address range for read-after-write hits.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      if (rd_done) rd_req = 1'b0;
      else if (!rd_req && $urandom_range(0, 3) == 0) begin
        rd_addr = AW'($urandom_range(0, 15)); rd_req = 1'b1;
      end
      if (wb_ack) begin wb_req = 1'b0; wb_full = 1'b0; end
      else if (!wb_req && $urandom_range(0, 3) == 0) begin
        wb_addr = AW'($urandom_range(0, 15)); wb_data = $urandom; wb_req = 1'b1;
      end
      if (wb_req && !wb_ack) wb_full = ($urandom_range(0, 3) == 0);
    end
    cyc = 0;
    while ((rd_req || wb_req) && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (rd_done) rd_req = 1'b0;
      if (wb_ack) begin wb_req = 1'b0; wb_full = 1'b0; end
    end
    chk("drain_complete", {rd_req, wb_req}, 2'b00);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
